// File: rtl/lut_phase_sequencer.sv
// rtl/lut_phase_sequencer.sv - LUT index sequencer with note-gate FSM and wrap-aligned config latch
// Optional burst limit: define LUT_SEQ_BURST_EN to add the burst_len input.
module lut_phase_sequencer #(
  parameter int TABLE_MAX = 360,
  parameter int IDX_W     = 16,
  parameter int DIV_W     = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gate,
  input  logic [IDX_W-1:0] step_in,
  input  logic [DIV_W-1:0] div_in,
  input  logic [1:0]       wave_sel_in,
`ifdef LUT_SEQ_BURST_EN
  input  logic [7:0]       burst_len,
`endif
  output logic [IDX_W-1:0] table_idx,
  output logic [1:0]       wave_sel,
  output logic             lut_en,
  output logic             sample_tick,
  output logic             period_wrap,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [IDX_W:0]   MAX_S    = (IDX_W+1)'(TABLE_MAX);
  localparam logic [IDX_W:0]   PERIOD_S = (IDX_W+1)'(TABLE_MAX + 1);
  localparam logic [IDX_W-1:0] MAX_STEP = IDX_W'(TABLE_MAX);

  state_t           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] step_q, step_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       wave_q, wave_d;

  logic             active;
  logic             tick;
  logic             wrap;
  logic             start;
  logic             burst_end;
  logic             latch_cfg;
  logic [IDX_W:0]   sum;
  logic [IDX_W:0]   idx_adv;
  logic [IDX_W-1:0] step_clamp;
  logic [DIV_W-1:0] div_clamp;

`ifdef LUT_SEQ_BURST_EN
  logic [7:0] burst_q, burst_d;
  logic [7:0] per_q, per_d;
  logic       armed_q, armed_d;
`endif

  // State and datapath registers; reset aborts any play immediately
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      step_q  <= IDX_W'(1);
      div_q   <= DIV_W'(1);
      wave_q  <= 2'd0;
`ifdef LUT_SEQ_BURST_EN
      burst_q <= 8'd0;
      per_q   <= 8'd0;
      armed_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      step_q  <= step_d;
      div_q   <= div_d;
      wave_q  <= wave_d;
`ifdef LUT_SEQ_BURST_EN
      burst_q <= burst_d;
      per_q   <= per_d;
      armed_q <= armed_d;
`endif
    end
  end

  // Tick, wrap and burst-end detection shared by the FSM and the datapath
  always_comb begin
    active     = (state_q != S_IDLE);
    tick       = active && (cnt_q == (div_q - DIV_W'(1)));
    sum        = {1'b0, idx_q} + {1'b0, step_q};
    wrap       = tick && (sum > MAX_S);
    idx_adv    = wrap ? (sum - PERIOD_S) : sum;
    step_clamp = (step_in > MAX_STEP) ? MAX_STEP : step_in;
    div_clamp  = (div_in == '0) ? DIV_W'(1) : div_in;
`ifdef LUT_SEQ_BURST_EN
    start      = gate && armed_q;
    burst_end  = (state_q == S_RUN) && wrap && (burst_q != 8'd0) &&
                 (({1'b0, per_q} + 9'd1) >= {1'b0, burst_q});
`else
    start      = gate;
    burst_end  = 1'b0;
`endif
  end

  // Next-state logic for the note-gate FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (burst_end)  state_d = S_IDLE;
        else if (!gate) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // A held index (step 0) can never wrap, so drop out at once
        if (gate)                    state_d = S_RUN;
        else if (wrap)               state_d = S_IDLE;
        else if (step_q == '0)       state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Divider, phase accumulator and config latch; config only moves at start or wrap
  always_comb begin
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    step_d    = step_q;
    div_d     = div_q;
    wave_d    = wave_q;
    latch_cfg = ((state_q == S_IDLE) && (state_d == S_RUN)) || wrap;
`ifdef LUT_SEQ_BURST_EN
    burst_d   = burst_q;
    per_d     = per_q;
    armed_d   = armed_q;
`endif

    if (latch_cfg) begin
      step_d = step_clamp;
      div_d  = div_clamp;
      wave_d = wave_sel_in;
    end

    if ((state_q == S_IDLE) || (state_d == S_IDLE) || tick) cnt_d = '0;
    else                                                    cnt_d = cnt_q + DIV_W'(1);

    if (state_d == S_IDLE) idx_d = '0;
    else if (tick)         idx_d = idx_adv[IDX_W-1:0];

`ifdef LUT_SEQ_BURST_EN
    if ((state_q == S_IDLE) && (state_d == S_RUN)) begin
      burst_d = burst_len;
      per_d   = 8'd0;
    end else if (wrap) begin
      per_d   = per_q + 8'd1;
    end
    // Re-arming after a finished burst needs the gate to fall first
    if (!gate)          armed_d = 1'b0 | 1'b1;
    else if (burst_end) armed_d = 1'b0;
`endif
  end

  // Output decode from state and registered datapath
  always_comb begin
    lut_en      = active;
    busy        = active;
    sample_tick = tick;
    period_wrap = wrap;
    table_idx   = idx_q;
    wave_sel    = wave_q;
  end

endmodule

// File: tb/tb_lut_phase_sequencer.sv
// tb/tb_lut_phase_sequencer.sv - directed self-checking bench for lut_phase_sequencer
module tb_lut_phase_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        gate = 1'b0;
  logic [15:0] step_in = 16'd1;
  logic [23:0] div_in = 24'd1;
  logic [1:0]  wave_sel_in = 2'd0;
  logic [7:0]  burst_len = 8'd0;
  logic [15:0] table_idx;
  logic [1:0]  wave_sel;
  logic        lut_en;
  logic        sample_tick;
  logic        period_wrap;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  lut_phase_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .gate        (gate),
    .step_in     (step_in),
    .div_in      (div_in),
    .wave_sel_in (wave_sel_in),
`ifdef LUT_SEQ_BURST_EN
    .burst_len   (burst_len),
`endif
    .table_idx   (table_idx),
    .wave_sel    (wave_sel),
    .lut_en      (lut_en),
    .sample_tick (sample_tick),
    .period_wrap (period_wrap),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    while (!sample_tick && n < 1000) begin
      cyc();
      n++;
    end
    if (!sample_tick) check("tick_timeout", 0, 1);
  endtask

  task automatic restart(input int s, input int d, input int w);
    rst  = 1'b1;
    gate = 1'b0;
    cyc();
    step_in     = 16'(s);
    div_in      = 24'(d);
    wave_sel_in = 2'(w);
    rst  = 1'b0;
    gate = 1'b1;
    cyc();
  endtask

  initial begin
    int n, w, k, cnt;
    int bad_gap, bad_idx, early_wrap, bad_wave, lost;
    int exp_idx[4];
    int exp_wrap[4];

    // Reset held with gate high
    rst = 1'b1; gate = 1'b1; step_in = 16'd1; div_in = 24'd4; wave_sel_in = 2'd0;
    repeat (3) cyc();
    check("rst_lut_en", lut_en, 0);
    check("rst_idx", table_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_tick", sample_tick, 0);
    check("rst_wrap", period_wrap, 0);
    check("rst_wave", wave_sel, 0);
    rst = 1'b0;
    cyc();
    check("start_lut_en", lut_en, 1);
    check("start_idx", table_idx, 0);
    check("start_busy", busy, 1);

    // Base stepping: div 4, step 1, full period
    bad_gap = 0; bad_idx = 0; early_wrap = 0;
    for (int t = 1; t <= 361; t++) begin
      wait_tick(n);
      if (n + 1 != 4) bad_gap++;
      w = period_wrap;
      cyc();
      if (t < 361) begin
        if (w != 0) early_wrap++;
        if (table_idx != 16'(t)) bad_idx++;
      end else begin
        check("base_wrap_pulse", w, 1);
        check("base_wrap_idx", table_idx, 0);
      end
    end
    check("base_gap", bad_gap, 0);
    check("base_idx_seq", bad_idx, 0);
    check("base_early_wrap", early_wrap, 0);

    // Config changes mid-period wait for the wrap
    for (int t = 0; t < 50; t++) begin
      wait_tick(n);
      cyc();
    end
    check("cfg_idx50", table_idx, 50);
    step_in = 16'd7; wave_sel_in = 2'd2; div_in = 24'd1;
    cnt = 0; bad_wave = 0; bad_gap = 0; bad_idx = 0;
    for (int t = 0; t < 400; t++) begin
      wait_tick(n);
      w = period_wrap;
      if (wave_sel != 2'd0) bad_wave++;
      if (n != 3) bad_gap++;
      cyc();
      cnt++;
      if (w != 0) break;
      if (table_idx != 16'(50 + cnt)) bad_idx++;
    end
    check("cfg_ticks_to_wrap", cnt, 311);
    check("cfg_wave_held", bad_wave, 0);
    check("cfg_div_held", bad_gap, 0);
    check("cfg_step_held", bad_idx, 0);
    check("cfg_wave_new", wave_sel, 2);
    check("cfg_idx_wrap", table_idx, 0);
    wait_tick(n);
    check("cfg_div_new", n, 0);
    cyc();
    check("cfg_idx7", table_idx, 7);
    wait_tick(n);
    cyc();
    check("cfg_idx14", table_idx, 14);

    // Reset mid-play aborts at once
    rst = 1'b1; gate = 1'b0;
    cyc();
    check("abort_lut_en", lut_en, 0);
    check("abort_idx", table_idx, 0);
    check("abort_wave", wave_sel, 0);
    check("abort_busy", busy, 0);

    // Wrap arithmetic: step 100, div 1
    exp_idx  = '{100, 200, 300, 39};
    exp_wrap = '{0, 0, 0, 1};
    restart(100, 1, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("wa_tick%0d", i), sample_tick, 1);
      w = period_wrap;
      cyc();
      check($sformatf("wa_idx%0d", i), table_idx, exp_idx[i]);
      check($sformatf("wa_wrap%0d", i), w, exp_wrap[i]);
    end

    // Drain: gate falls at idx 200
    restart(1, 1, 0);
    repeat (200) cyc();
    check("drain_idx200", table_idx, 200);
    gate = 1'b0;
    lost = 0; k = 0;
    while (!period_wrap && k < 500) begin
      if (!lut_en || !busy) lost++;
      cyc();
      k++;
    end
    check("drain_reached_wrap", period_wrap, 1);
    check("drain_cycles", k, 160);
    check("drain_lut_en_held", lost, 0);
    cyc();
    check("drain_end_lut_en", lut_en, 0);
    check("drain_end_busy", busy, 0);
    check("drain_end_idx", table_idx, 0);

    // Drain then gate re-raised at idx 300
    restart(1, 1, 0);
    repeat (200) cyc();
    gate = 1'b0;
    repeat (100) cyc();
    check("rerun_busy", busy, 1);
    check("rerun_idx300", table_idx, 300);
    gate = 1'b1;
    cyc();
    check("rerun_idx301", table_idx, 301);
    repeat (59) cyc();
    check("rerun_idx360", table_idx, 360);
    check("rerun_wrap", period_wrap, 1);
    cyc();
    check("rerun_after_idx", table_idx, 0);
    check("rerun_after_lut_en", lut_en, 1);
    check("rerun_after_busy", busy, 1);

    // div_in = 0 ticks every cycle
    restart(1, 0, 0);
    check("div0_tick_a", sample_tick, 1);
    cyc();
    check("div0_idx1", table_idx, 1);
    check("div0_tick_b", sample_tick, 1);
    cyc();
    check("div0_idx2", table_idx, 2);

    // step_in = 500 clamps to 360
    exp_idx  = '{360, 359, 358, 357};
    exp_wrap = '{0, 1, 1, 1};
    restart(500, 1, 0);
    for (int i = 0; i < 3; i++) begin
      w = period_wrap;
      cyc();
      check($sformatf("clamp_idx%0d", i), table_idx, exp_idx[i]);
      check($sformatf("clamp_wrap%0d", i), w, exp_wrap[i]);
    end

    // step_in = 0: held index, drain exits the next cycle
    restart(0, 1, 0);
    repeat (3) cyc();
    check("step0_idx", table_idx, 0);
    check("step0_wrap", period_wrap, 0);
    gate = 1'b0;
    cyc();
    check("step0_drain_busy", busy, 1);
    check("step0_drain_lut_en", lut_en, 1);
    cyc();
    check("step0_idle_busy", busy, 0);
    check("step0_idle_lut_en", lut_en, 0);

    // Wrap and gate fall together: wrap taken, config latched, go to DRAIN
    restart(100, 1, 0);
    repeat (3) cyc();
    check("simul_idx300", table_idx, 300);
    check("simul_wrap", period_wrap, 1);
    step_in = 16'd50;
    gate = 1'b0;
    cyc();
    check("simul_idx39", table_idx, 39);
    check("simul_busy", busy, 1);
    cyc();
    check("simul_idx89", table_idx, 89);
    check("simul_drain_busy", busy, 1);

`ifdef LUT_SEQ_BURST_EN
    // Burst of two periods ends while gate is still high
    burst_len = 8'd2;
    restart(100, 1, 0);
    cnt = 0;
    repeat (20) begin
      if (period_wrap) cnt++;
      cyc();
    end
    check("burst_wraps", cnt, 2);
    check("burst_busy", busy, 0);
    check("burst_lut_en", lut_en, 0);
    gate = 1'b0;
    cyc();
    gate = 1'b1;
    cyc();
    check("burst_rearm", busy, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
